membrane_spike_store: RTL and testbench

- Clocked write-back store sitting between the partial-sum adders and the rest of the SNN datapath.
- Holds the per-neuron membrane potentials of one 3x3 output map.
- Answers adder read requests with the stored potential and absorbs potential write-backs.
- Accumulates output spikes into a bit map, released as one word when an adder signals done.

---
 rtl/membrane_spike_store_if.sv | 28 ++
 rtl/membrane_spike_store.sv | 173 +++++++++++++++++
 tb/tb_membrane_spike_store.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/membrane_spike_store_if.sv
`default_nettype none
// ============================================================================
//  Module   : membrane_spike_store_if
//  Purpose  : Request/response bus between partial-sum adders and the
//             membrane spike store (request in, read response out).
//  Revision : 1.0 - initial release
// ============================================================================
interface membrane_spike_store_if #(
  parameter int unsigned WIDTH = 34
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/membrane_spike_store.sv
`default_nettype none
// ============================================================================
//  Module   : membrane_spike_store
//  Purpose  : Membrane potential store and spike-map accumulator for one
//             output map; serves adder reads, absorbs write-backs and spikes.
//             Optional macro MP_LEAK_EN: leak all potentials on each flush.
//  Revision : 1.0 - initial release
// ============================================================================
module membrane_spike_store #(
  parameter int unsigned WIDTH     = 34,
  parameter int unsigned MP_WIDTH  = 8,
  parameter int unsigned ROWS      = 3,
  parameter int unsigned COLS      = 3,
  parameter logic [3:0]  SELF_ADDR = 4'b0001,
  parameter int unsigned LEAK      = 1
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  membrane_spike_store_if.slave       bus,
  output logic [ROWS*COLS-1:0]        spike_map,
  output logic                        spike_map_valid,
  output logic [7:0]                  timestep,
  output logic [7:0]                  drop_cnt
);

  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [MP_WIDTH-1:0] LEAK_MP = MP_WIDTH'(LEAK);
`ifdef MP_LEAK_EN
  localparam bit LEAK_ON = 1'b1;
`else
  localparam bit LEAK_ON = 1'b0;
`endif

  localparam logic [1:0] T_WRITE = 2'b00;
  localparam logic [1:0] T_SPIKE = 2'b01;
  localparam logic [1:0] T_READ  = 2'b10;
  localparam logic [1:0] T_DONE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [MP_WIDTH-1:0]         mp_q [N];
  logic [MP_WIDTH-1:0]         mp_d [N];
  logic [N-1:0]                acc_q, acc_d;
  logic [N-1:0]                map_q, map_d;
  logic [WIDTH-1:0]            out_data_q, out_data_d;
  logic [7:0]                  timestep_q, timestep_d;
  logic [7:0]                  drop_q, drop_d;

  logic [3:0]                  pkt_src;
  logic [3:0]                  pkt_dst;
  logic [1:0]                  pkt_type;
  logic [1:0]                  pkt_row;
  logic [1:0]                  pkt_col;
  logic [MP_WIDTH-1:0]         pkt_mp;
  logic [IDX_W-1:0]            pkt_idx;
  logic                        in_ready;
  logic                        accept;
  logic                        drop;
  logic                        unused_payload;

  assign pkt_src  = bus.in_data[33:30];
  assign pkt_dst  = bus.in_data[29:26];
  assign pkt_type = bus.in_data[25:24];
  assign pkt_row  = bus.in_data[3:2];
  assign pkt_col  = bus.in_data[1:0];
  assign pkt_mp   = bus.in_data[4 +: MP_WIDTH];
  assign pkt_idx  = IDX_W'(32'(pkt_row) * COLS + 32'(pkt_col));
  assign unused_payload = ^bus.in_data[23:4+MP_WIDTH];

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = bus.in_valid && in_ready;

  // Done packets carry no neuron address, only the 4'hF marker.
  always_comb begin
    drop = 1'b0;
    if (pkt_dst != SELF_ADDR) begin
      drop = 1'b1;
    end else if (pkt_type == T_DONE) begin
      drop = (bus.in_data[3:0] != 4'hF);
    end else begin
      drop = (32'(pkt_row) >= ROWS) || (32'(pkt_col) >= COLS);
    end
  end

  always_comb begin
    state_d    = state_q;
    mp_d       = mp_q;
    acc_d      = acc_q;
    map_d      = map_q;
    out_data_d = out_data_q;
    timestep_d = timestep_q;
    drop_d     = drop_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (drop) begin
            if (drop_q != 8'hFF) begin
              drop_d = drop_q + 8'd1;
            end
          end else begin
            case (pkt_type)
              T_WRITE: mp_d[pkt_idx] = pkt_mp;
              T_SPIKE: acc_d[pkt_idx] = 1'b1;
              T_READ: begin
                // Potential sampled now so the response is ready next cycle.
                out_data_d = {SELF_ADDR, pkt_src, T_READ,
                              {(24-MP_WIDTH){1'b0}}, mp_q[pkt_idx]};
                state_d    = ST_RESP;
              end
              default: begin
                map_d      = acc_q;
                acc_d      = '0;
                timestep_d = timestep_q + 8'd1;
                state_d    = ST_FLUSH;
              end
            endcase
          end
        end
      end
      ST_RESP: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (LEAK_ON) begin
          for (int i = 0; i < int'(N); i++) begin
            mp_d[i] = (mp_q[i] > LEAK_MP) ? (mp_q[i] - LEAK_MP) : '0;
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mp_q       <= '{default: '0};
      acc_q      <= '0;
      map_q      <= '0;
      out_data_q <= '0;
      timestep_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      mp_q       <= mp_d;
      acc_q      <= acc_d;
      map_q      <= map_d;
      out_data_q <= out_data_d;
      timestep_q <= timestep_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (state_q == ST_RESP);
  assign bus.out_data    = out_data_q;
  assign spike_map       = map_q;
  assign spike_map_valid = (state_q == ST_FLUSH);
  assign timestep        = timestep_q;
  assign drop_cnt        = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_membrane_spike_store.sv
`default_nettype none
// ============================================================================
//  Module   : tb_membrane_spike_store
//  Purpose  : Directed self-checking bench for membrane_spike_store.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_membrane_spike_store;

  localparam logic [3:0] SELF = 4'b0001;

  logic       clk;
  logic       reset;
  logic [8:0] spike_map;
  logic       spike_map_valid;
  logic [7:0] timestep;
  logic [7:0] drop_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  membrane_spike_store_if #(.WIDTH(34)) bus ();

  membrane_spike_store dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .spike_map       (spike_map),
    .spike_map_valid (spike_map_valid),
    .timestep        (timestep),
    .drop_cnt        (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] pkt(input logic [3:0] src, input logic [3:0] dst,
                                      input logic [1:0] ty, input logic [23:0] pl);
    return {src, dst, ty, pl};
  endfunction

  function automatic logic [23:0] pl(input logic [1:0] row, input logic [1:0] col,
                                     input logic [7:0] val);
    return {12'h000, val, row, col};
  endfunction

  function automatic logic [33:0] resp(input logic [3:0] src, input logic [7:0] mp);
    return {SELF, src, 2'b10, 16'h0000, mp};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp)
    else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called right after a negedge; returns at the negedge after the accepting edge.
  task automatic send(input string tag, input logic [33:0] p);
    check({tag, "_rdy"}, 64'(bus.in_ready), 64'(1));
    bus.in_data  = p;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(negedge clk);
  endtask

  task automatic release_resp();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_check(input string tag, input logic [3:0] src, input logic [1:0] row,
                            input logic [1:0] col, input logic [7:0] exp_mp);
    send(tag, pkt(src, SELF, 2'b10, pl(row, col, 8'h00)));
    check({tag, "_ov"}, 64'(bus.out_valid), 64'(1));
    check({tag, "_od"}, 64'(bus.out_data), 64'(resp(src, exp_mp)));
    release_resp();
    check({tag, "_back"}, 64'(bus.out_valid), 64'(0));
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_map", 64'(spike_map), 64'(0));
    check("rst_map_valid", 64'(spike_map_valid), 64'(0));
    check("rst_timestep", 64'(timestep), 64'(0));
    check("rst_drop", 64'(drop_cnt), 64'(0));

    read_check("rd12_init", 4'b0011, 2'd1, 2'd2, 8'd0);

    // Write then immediate read, with a stalled response
    send("wr21", pkt(4'b0110, SELF, 2'b00, pl(2'd2, 2'd1, 8'd37)));
    send("rd21", pkt(4'b0110, SELF, 2'b10, pl(2'd2, 2'd1, 8'd0)));
    check("rd21_ov", 64'(bus.out_valid), 64'(1));
    check("rd21_od", 64'(bus.out_data), 64'(resp(4'b0110, 8'd37)));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_od", 64'(bus.out_data), 64'(resp(4'b0110, 8'd37)));
      check("stall_ov", 64'(bus.out_valid), 64'(1));
      check("stall_ir", 64'(bus.in_ready), 64'(0));
    end
    release_resp();
    check("after_stall_ir", 64'(bus.in_ready), 64'(1));

    // Upper payload bits beyond the potential width are ignored
    send("wr00_wide", pkt(4'b0010, SELF, 2'b00, 24'hFFF2A0));
    read_check("rd00_wide", 4'b0010, 2'd0, 2'd0, 8'h2A);

    // Spike accumulation and flush
    send("sp00", pkt(4'b0010, SELF, 2'b01, pl(2'd0, 2'd0, 8'd0)));
    send("sp11", pkt(4'b0010, SELF, 2'b01, pl(2'd1, 2'd1, 8'd0)));
    send("sp22", pkt(4'b0010, SELF, 2'b01, pl(2'd2, 2'd2, 8'd0)));
    send("sp11_dup", pkt(4'b0010, SELF, 2'b01, pl(2'd1, 2'd1, 8'd0)));
    send("done1", pkt(4'b0010, SELF, 2'b11, 24'h00000F));
    check("done1_mv", 64'(spike_map_valid), 64'(1));
    check("done1_map", 64'(spike_map), 64'(9'b100010001));
    check("done1_ts", 64'(timestep), 64'(1));
    check("done1_ir", 64'(bus.in_ready), 64'(0));
    @(negedge clk);
    check("done1_mv_end", 64'(spike_map_valid), 64'(0));
    check("done1_map_hold", 64'(spike_map), 64'(9'b100010001));
    send("done2", pkt(4'b0010, SELF, 2'b11, 24'h00000F));
    check("done2_mv", 64'(spike_map_valid), 64'(1));
    check("done2_map", 64'(spike_map), 64'(0));
    check("done2_ts", 64'(timestep), 64'(2));
    @(negedge clk);

    // Discarded packets
    send("drop_dst", pkt(4'b0010, 4'b0000, 2'b00, pl(2'd0, 2'd0, 8'd99)));
    send("drop_row", pkt(4'b0010, SELF, 2'b00, pl(2'd3, 2'd0, 8'd99)));
    send("drop_done", pkt(4'b0010, SELF, 2'b11, 24'h00000E));
    check("drop_cnt", 64'(drop_cnt), 64'(3));
    check("drop_mv", 64'(spike_map_valid), 64'(0));
    check("drop_ts", 64'(timestep), 64'(2));
    read_check("drop_rd00", 4'b0010, 2'd0, 2'd0, 8'h2A);

    // Reset while a response is pending
    send("wr11", pkt(4'b0100, SELF, 2'b00, pl(2'd1, 2'd1, 8'd50)));
    send("rd11", pkt(4'b0100, SELF, 2'b10, pl(2'd1, 2'd1, 8'd0)));
    check("rd11_ov", 64'(bus.out_valid), 64'(1));
    check("rd11_od", 64'(bus.out_data), 64'(resp(4'b0100, 8'd50)));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_ov", 64'(bus.out_valid), 64'(0));
    check("mid_rst_od", 64'(bus.out_data), 64'(0));
    check("mid_rst_ir", 64'(bus.in_ready), 64'(1));
    check("mid_rst_drop", 64'(drop_cnt), 64'(0));
    check("mid_rst_ts", 64'(timestep), 64'(0));
    read_check("mid_rst_rd11", 4'b0100, 2'd1, 2'd1, 8'd0);
    read_check("mid_rst_rd21", 4'b0100, 2'd2, 2'd1, 8'd0);
    read_check("mid_rst_rd00", 4'b0100, 2'd0, 2'd0, 8'd0);

    // Flush effect on stored potentials
    send("wr01", pkt(4'b0101, SELF, 2'b00, pl(2'd0, 2'd1, 8'd5)));
    send("wr02", pkt(4'b0101, SELF, 2'b00, pl(2'd0, 2'd2, 8'd0)));
    send("done_leak", pkt(4'b0101, SELF, 2'b11, 24'h00000F));
    @(negedge clk);
`ifdef MP_LEAK_EN
    read_check("leak_rd01", 4'b0101, 2'd0, 2'd1, 8'd4);
`else
    read_check("leak_rd01", 4'b0101, 2'd0, 2'd1, 8'd5);
`endif
    read_check("leak_rd02", 4'b0101, 2'd0, 2'd2, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
